// File: rtl/lfa_pkg.sv
// Shared definitions for the line-follower-array ADC front end and the line-following stage.
package lfa_pkg;

  localparam int LFA_DATA_W     = 12;
  localparam int ADC_FRAME_BITS = 16;

  localparam logic [2:0] LFA_CH_L = 3'd3;
  localparam logic [2:0] LFA_CH_M = 3'd4;
  localparam logic [2:0] LFA_CH_R = 3'd5;

  localparam int LFA_BLACK_TH = 1200;
  localparam int LFA_WHITE_TH = 700;

  typedef enum logic [1:0] {
    GAP   = 2'd0,
    SHIFT = 2'd1,
    STORE = 2'd2
  } adc_state_e;

  // ADC128S022 control word: two don't-care bits, 3-bit channel address, then zeros.
  function automatic logic [ADC_FRAME_BITS-1:0] adc_ctrl_word(input logic [2:0] addr);
    return {2'b00, addr, 11'b0};
  endfunction

endpackage

// File: rtl/lfa_adc_sampler_sck_gen.sv
// SCLK generator: divides the system clock into an idle-high serial clock with edge strobes.
module adc_sck_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sck,
  output logic sck_fall,
  output logic sck_rise
);

  logic [7:0] half;
  logic       term;

  assign term     = (half == 8'(CLK_DIV - 1));
  // Strobes mark the clock on whose edge adc_sck will toggle.
  assign sck_fall = run && term && sck;
  assign sck_rise = run && term && !sck;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      half <= 8'd0;
      sck  <= 1'b1;
    end else if (term) begin
      half <= 8'd0;
      sck  <= ~sck;
    end else begin
      half <= half + 8'd1;
    end
  end

endmodule

// File: rtl/lfa_adc_sampler.sv
// Round-robin ADC128S022 sampler for the left/middle/right line-follower photodiodes.
module lfa_adc_sampler
  import lfa_pkg::*;
#(
  parameter int         CLK_DIV    = 25,
  parameter int         GAP_CYCLES = 4,
  parameter logic [2:0] CH_LEFT    = LFA_CH_L,
  parameter logic [2:0] CH_MIDDLE  = LFA_CH_M,
  parameter logic [2:0] CH_RIGHT   = LFA_CH_R
) (
  input  logic                  clk_50M,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  adc_cs_n,
  output logic                  adc_sck,
  output logic                  adc_din,
  input  logic                  adc_dout,
  output logic [LFA_DATA_W-1:0] left,
  output logic [LFA_DATA_W-1:0] middle,
  output logic [LFA_DATA_W-1:0] right,
  output logic                  data_valid
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  adc_state_e                state;
  logic [3:0]                gap_cnt;
  logic [3:0]                bit_cnt;
  logic [ADC_FRAME_BITS-1:0] ctrl_p0;
  logic [LFA_DATA_W-1:0]     shift_p0;
  logic [2:0]                addr;
  logic [2:0]                prev_addr;
  logic                      prime;
  logic [2:0]                fresh;
  logic [2:0]                hit;
  logic [2:0]                fresh_next;
  logic                      sck_fall;
  logic                      sck_rise;

  function automatic logic [2:0] next_addr(input logic [2:0] a);
    if (a == CH_LEFT)   return CH_MIDDLE;
    if (a == CH_MIDDLE) return CH_RIGHT;
    return CH_LEFT;
  endfunction

  adc_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk      (clk_50M),
    .reset    (reset),
    .run      (state == SHIFT),
    .sck      (adc_sck),
    .sck_fall (sck_fall),
    .sck_rise (sck_rise)
  );

  // The ADC answers one frame late, so the result being stored belongs to prev_addr.
  always_comb begin
    hit = 3'b000;
    if (prev_addr == CH_LEFT)        hit[0] = 1'b1;
    else if (prev_addr == CH_MIDDLE) hit[1] = 1'b1;
    else if (prev_addr == CH_RIGHT)  hit[2] = 1'b1;
    fresh_next = fresh | hit;
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state      <= GAP;
      gap_cnt    <= 4'd0;
      bit_cnt    <= 4'd0;
      addr       <= CH_LEFT;
      prev_addr  <= CH_LEFT;
      prime      <= 1'b1;
      fresh      <= 3'b000;
      adc_cs_n   <= 1'b1;
      adc_din    <= 1'b0;
      left       <= '0;
      middle     <= '0;
      right      <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        GAP: begin
          adc_cs_n <= 1'b1;
          if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 4'd1;
          end else if (enable) begin
            state    <= SHIFT;
            adc_cs_n <= 1'b0;
            adc_din  <= 1'b0;
            bit_cnt  <= 4'd0;
            ctrl_p0  <= adc_ctrl_word(addr);
          end
        end
        SHIFT: begin
          if (sck_fall) begin
            adc_din <= ctrl_p0[ADC_FRAME_BITS-1];
            ctrl_p0 <= {ctrl_p0[ADC_FRAME_BITS-2:0], 1'b0};
          end
          // Only 12 bits are kept: the ADC's leading-zero nibble shifts out the top.
          if (sck_rise) begin
            shift_p0 <= {shift_p0[LFA_DATA_W-2:0], adc_dout};
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) state <= STORE;
          end
        end
        STORE: begin
          adc_cs_n  <= 1'b1;
          gap_cnt   <= 4'd0;
          state     <= GAP;
          addr      <= next_addr(addr);
          prev_addr <= addr;
          if (prime) begin
            prime <= 1'b0;
          end else begin
            if (hit[0]) left   <= shift_p0;
            if (hit[1]) middle <= shift_p0;
            if (hit[2]) right  <= shift_p0;
            if (hit[2] && fresh_next == 3'b111) begin
              data_valid <= 1'b1;
              fresh      <= 3'b000;
            end else begin
              fresh <= fresh_next;
            end
          end
        end
        default: state <= GAP;
      endcase
    end
  end

endmodule

// File: doc/lfa_adc_sampler.md
Name: lfa_adc_sampler

Overview:
Upstream front end for the line-following controller. It drives the ADC128S022 serial ADC that digitises the three line-follower-array (LFA) photodiodes. It round-robins the left, middle and right channels and presents registered 12-bit left/middle/right words, plus a one-cycle valid strobe per completed triple. Outputs connect directly to the 12-bit left/middle/right inputs of the line-following stage.

Parameters:
CLK_DIV, 25, system clocks per SCLK half-period (50 MHz -> 1 MHz SCLK); legal 2..255
GAP_CYCLES, 4, system clocks CS_N held high between frames; legal 1..15
CH_LEFT, 3'd3, ADC channel address of left sensor
CH_MIDDLE, 3'd4, ADC channel address of middle sensor
CH_RIGHT, 3'd5, ADC channel address of right sensor

Ports:
clk_50M  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  1 = keep sampling; 0 = finish current frame then idle
adc_cs_n  output  1  ADC chip select, active low
adc_sck  output  1  ADC serial clock, idles high
adc_din  output  1  ADC control bit stream (MSB first)
adc_dout  input  1  ADC conversion bit stream (MSB first)
left  output  12  latest left-channel conversion
middle  output  12  latest middle-channel conversion
right  output  12  latest right-channel conversion
data_valid  output  1  one-cycle pulse when right is updated and all three words are fresh since reset

Behaviour:
- Reset (synchronous, active-high, wins over everything): adc_cs_n=1, adc_sck=1, adc_din=0, left/middle/right=0, data_valid=0, state=GAP, gap counter=0, next address=CH_LEFT, prime flag=1, fresh mask=3'b000.
- Reset mid-frame: on the next edge adc_cs_n=1 and adc_sck=1. The partial frame is discarded, and priming repeats.
- FSM states: GAP, SHIFT, STORE.
- GAP state:
  - adc_cs_n=1; count GAP_CYCLES clocks.
  - If enable=1 at the end of the count: go to SHIFT, drop adc_cs_n, and load the control word {2'b00, addr, 11'b0}.
  - If enable=0: hold in GAP.
- SHIFT state: 16 SCLK periods, each of 2*CLK_DIV clocks; a half-period counter toggles adc_sck.
  - Falling edge k (k=0..15): adc_din = control bit 15-k.
  - Rising edge k: shift adc_dout into a 16-bit shift register, LSB-in.
  - After the 16th rising edge, adc_sck stays high and the FSM goes to STORE.
  - enable is ignored during SHIFT.
- STORE state, one clock:
  - adc_cs_n=1.
  - The result is shift[11:0] (the top 4 bits are ADC leading zeros and are ignored). It belongs to the address sent in the PREVIOUS frame, because the ADC is pipelined by one frame.
  - If the prime flag is set: discard the result and clear the flag.
  - Otherwise: write the result to left, middle or right according to the previous address, and set the matching fresh bit.
  - Advance the address L->M->R->L. Go to GAP.
- data_valid:
  - Asserted for exactly the STORE cycle in which right is written AND the fresh mask is 3'b111 after the write. The mask is then cleared.
  - It is registered and coincident with the right update.
- Latency:
  - One frame = 32*CLK_DIV + GAP_CYCLES + 1 clocks (805 at default).
  - After reset release, first data_valid comes after 4 frames (prime + L + M + R results): 4*805 = 3220 clocks at default, ±1 clock.
  - Steady state: one valid per 3 frames (2415 clocks).
- Outputs hold their value between updates and are never glitched mid-frame. left/middle/right change only in STORE.
- enable deasserted mid-SHIFT: the frame completes and stores normally, then the FSM idles in GAP. The prime flag and address sequence are preserved, so there is no re-prime on resume.
- adc_dout is sampled directly. adc_cs_n, adc_sck and adc_din are driven from flops.
- All counters saturate/wrap explicitly:
  - half-period counter 0..CLK_DIV-1
  - bit counter 0..15
  - gap counter 0..GAP_CYCLES-1

Decomposition:
- Shared package lfa_pkg:
  - LFA_DATA_W=12, ADC_FRAME_BITS=16
  - channel address constants (L=3, M=4, R=5)
  - line thresholds LFA_BLACK_TH=1200, LFA_WHITE_TH=700, shared with the line-following stage
  - FSM state enum {GAP, SHIFT, STORE}
- One sub-module, adc_sck_gen:
  - half-period counter
  - outputs adc_sck, plus sck_fall/sck_rise one-clock strobes
  - run/stop input; stop leaves adc_sck high

Test Plan:
- ADC model returns L=12'd1500, M=12'd300, R=12'd650, reset released with enable=1 -> first data_valid at clock 3220±1 with left=1500, middle=300, right=650; the prime-frame result never appears on any output.
- Steady sampling, ADC model values changed to L=12'd600, M=12'd1300, R=12'd600 -> data_valid period exactly 2415 clocks; the new triple appears within 2 valid strobes; adc_din address bits sequence 011,100,101 repeating.
- Bit-level check -> adc_sck idles high; adc_din stable across each rising edge; exactly 16 rising edges per adc_cs_n low window; adc_cs_n high ≥ GAP_CYCLES clocks.
- Reset asserted at bit 7 of a frame -> next clock adc_cs_n=1, adc_sck=1, outputs=0; after release, first data_valid again at clock 3220±1.
- enable dropped at bit 3 of the middle-address frame -> that frame finishes and stores; no further adc_cs_n activity; enable re-raised -> sequence resumes at the right address without re-prime.
- ADC model returns 12'hFFF and 12'h000 with leading nibble forced to 4'hF -> outputs 4095 and 0; leading bits ignored.
